branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the pipeline's branch condition handler and PC-select logic.
- Resolves unconditional jumps (J/JAL, JR) in ID and conditional branches (BEQ/BNE/BLEZ/BGTZ/REGIMM) in EX, from the Z/N flags and the rt field.
- Drives next-PC selection and per-stage flush, with a configurable delay slot.
- Keeps saturating statistics counters of branches seen and branches taken. Sits between the IF PC register and the ID/EX pipeline latches.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- REG_W, 32, width of the rs register value used by JR.
- DELAY_SLOT, 1, 1 = one architectural delay slot, 0 = none.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; freezes all state.
- id_valid  in  1  ID stage holds a valid instruction.
- id_b_instr  in  1  ID instruction is a conditional branch.
- id_jump  in  1  ID instruction is J/JAL.
- id_jr  in  1  ID instruction is JR/JALR.
- id_opcode  in  6  ID opcode field, bits 31:26.
- id_rt  in  5  ID rt field, bits 20:16.
- id_ta  in  ADDR_W  branch or jump target computed in ID.
- id_rs_val  in  REG_W  rs value, used as the JR target.
- ex_z  in  1  EX compare zero flag.
- ex_n  in  1  EX compare negative flag.
- npc_in  in  ADDR_W  sequential next PC.
- next_pc  out  ADDR_W  PC to load at the next edge.
- redirect  out  1  next_pc is not npc_in.
- flush_if  out  1  squash the instruction entering IF/ID.
- flush_id  out  1  squash the instruction entering ID/EX.
- busy  out  1  a branch is resolving in EX.
- branch_cnt  out  CNT_W  conditional branches resolved.
- taken_cnt  out  CNT_W  conditional branches taken.

Behaviour:
- Reset (reset_n low, async): state=IDLE, EX branch registers cleared, counters=0. Outputs: redirect=0, flush_if=0, flush_id=0, busy=0, next_pc=npc_in.
- States:
  - IDLE: no branch in EX.
  - BR_EX: a captured branch is in EX; busy=1.
- Capture: at a rising edge with stall=0, id_valid=1, id_b_instr=1, and no taken redirect this cycle, latch opcode, rt and id_ta into the EX registers and go to BR_EX. Otherwise go (or stay) in IDLE.
- Condition, evaluated combinationally in BR_EX on latched opcode/rt and live ex_z/ex_n:
  - 000100 BEQ: Z
  - 000101 BNE: !Z
  - 000110 BLEZ: Z|N
  - 000111 BGTZ: !Z&!N
  - 000001 REGIMM, rt=00000 or 10000 (BLTZ/BLTZAL): N
  - 000001 REGIMM, rt=00001 or 10001 (BGEZ/BGEZAL): !N
  - Any other opcode/rt: not taken.
- Taken branch (BR_EX, cond=1, stall=0): redirect=1, next_pc=latched TA. Squash count is 2-DELAY_SLOT: DELAY_SLOT=1 gives flush_if=1 only; DELAY_SLOT=0 gives flush_if=1 and flush_id=1.
- Jump in ID (id_valid & (id_jump|id_jr), stall=0, no taken EX branch): redirect=1.
  - next_pc = id_ta for J, or id_rs_val zero-extended/truncated to ADDR_W for JR.
  - flush_if = (DELAY_SLOT==0). Zero resolution latency.
- id_jump and id_jr both high: JR wins.
- Priority: taken EX branch > ID jump > npc_in. A branch or jump in ID during a taken EX redirect is ignored and not captured.
- Back-to-back: not-taken EX branch plus a new branch in ID means the new branch is captured; state stays BR_EX.
- stall=1:
  - redirect, flush_if and flush_id are forced to 0; next_pc=npc_in.
  - State, EX registers and counters hold. Flags are re-evaluated once stall drops.
- Counters: on each BR_EX edge with stall=0, branch_cnt+=1, and taken_cnt+=1 if taken. Both saturate at 2^CNT_W-1 with no wrap.
- Reset mid-branch returns the block to IDLE; the pending branch is discarded with no redirect.

Test Plan:
- Reset mid-BR_EX (BEQ latched, reset_n low for 1 cycle) -> redirect=0, busy=0, counters=0 immediately and after release.
- BEQ in ID with id_ta=0x0000_0040, next cycle ex_z=1, DELAY_SLOT=1 -> in BR_EX: redirect=1, next_pc=0x40, flush_if=1, flush_id=0, taken_cnt=1, branch_cnt=1.
- REGIMM, rt=00001 (BGEZ), ex_n=1 -> redirect=0, next_pc=npc_in, branch_cnt increments, taken_cnt unchanged; with DELAY_SLOT=0 a taken BNE (ex_z=0) also asserts flush_id=1.
- JR with id_rs_val=0x0000_1234 in ID, IDLE, DELAY_SLOT=0 -> same cycle: redirect=1, next_pc=0x1234, flush_if=1; a simultaneous taken EX branch instead gives next_pc=EX TA and the JR is ignored.
- Taken BGTZ in EX with stall=1 for 3 cycles -> redirect=0 and busy=1 throughout; redirect=1 on the first cycle with stall=0, counted once.
- CNT_W=2, five taken branches -> branch_cnt=3 and taken_cnt=3 (saturated, no wrap).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution and PC select. Jumps resolve in ID. Conditional branches are
// latched in ID and resolved in EX from the Z/N flags. Saturating branch statistics.
module branch_resolve_unit #(
  parameter int ADDR_W     = 32,
  parameter int REG_W      = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              id_valid,
  input  logic              id_b_instr,
  input  logic              id_jump,
  input  logic              id_jr,
  input  logic [5:0]        id_opcode,
  input  logic [4:0]        id_rt,
  input  logic [ADDR_W-1:0] id_ta,
  input  logic [REG_W-1:0]  id_rs_val,
  input  logic              ex_z,
  input  logic              ex_n,
  input  logic [ADDR_W-1:0] npc_in,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect,
  output logic              flush_if,
  output logic              flush_id,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic {IDLE = 1'b0, BR_EX = 1'b1} state_t;

  localparam logic NO_SLOT = (DELAY_SLOT == 0);

  state_t            state, state_nxt;
  logic [5:0]        ex_opcode;
  logic [4:0]        ex_rt;
  logic [ADDR_W-1:0] ex_ta;
  logic [ADDR_W-1:0] jr_target;
  logic              cond, taken, jump_now, capture;

  generate
    if (REG_W >= ADDR_W) begin : g_trunc
      assign jr_target = id_rs_val[ADDR_W-1:0];
    end else begin : g_zext
      assign jr_target = {{(ADDR_W-REG_W){1'b0}}, id_rs_val};
    end
  endgenerate

  // Branch condition from the latched opcode/rt and the live EX flags.
  always_comb begin
    cond = 1'b0;
    case (ex_opcode)
      6'b000100: cond = ex_z;
      6'b000101: cond = ~ex_z;
      6'b000110: cond = ex_z | ex_n;
      6'b000111: cond = ~ex_z & ~ex_n;
      6'b000001: begin
        case (ex_rt)
          5'b00000, 5'b10000: cond = ex_n;
          5'b00001, 5'b10001: cond = ~ex_n;
          default:            cond = 1'b0;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

  assign taken    = (state == BR_EX) & cond & ~stall;
  assign jump_now = id_valid & (id_jump | id_jr) & ~stall & ~taken;
  assign capture  = id_valid & id_b_instr & ~stall & ~taken;

  always_comb begin
    state_nxt = state;
    next_pc   = npc_in;
    redirect  = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    busy      = (state == BR_EX);
    if (!stall) begin
      state_nxt = capture ? BR_EX : IDLE;
    end
    // A taken EX branch outranks an ID jump, which outranks sequential flow.
    if (taken) begin
      next_pc  = ex_ta;
      redirect = 1'b1;
      flush_if = 1'b1;
      flush_id = NO_SLOT;
    end else if (jump_now) begin
      next_pc  = id_jr ? jr_target : id_ta;
      redirect = 1'b1;
      flush_if = NO_SLOT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_opcode <= '0;
      ex_rt     <= '0;
      ex_ta     <= '0;
    end else if (capture) begin
      ex_opcode <= id_opcode;
      ex_rt     <= id_rt;
      ex_ta     <= id_ta;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if ((state == BR_EX) && !stall) begin
      if (branch_cnt != {CNT_W{1'b1}}) branch_cnt <= branch_cnt + 1'b1;
      if (taken && (taken_cnt != {CNT_W{1'b1}})) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: three instances (delay slot, no delay slot, 2-bit
// counters) share stimulus and are checked against a per-cycle reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, id_valid, id_b_instr, id_jump, id_jr;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rt;
  logic [31:0] id_ta, id_rs_val, npc_in;
  logic        ex_z, ex_n;

  logic [31:0] npc_w [3];
  logic        red_w [3], fif_w [3], fid_w [3], busy_w [3];
  logic [15:0] bc_w [3], tc_w [3];
  logic [1:0]  sat_bc, sat_tc;

  assign bc_w[2] = {14'b0, sat_bc};
  assign tc_w[2] = {14'b0, sat_tc};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DELAY_SLOT(1)) u0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .id_valid(id_valid),
    .id_b_instr(id_b_instr), .id_jump(id_jump), .id_jr(id_jr),
    .id_opcode(id_opcode), .id_rt(id_rt), .id_ta(id_ta), .id_rs_val(id_rs_val),
    .ex_z(ex_z), .ex_n(ex_n), .npc_in(npc_in), .next_pc(npc_w[0]),
    .redirect(red_w[0]), .flush_if(fif_w[0]), .flush_id(fid_w[0]),
    .busy(busy_w[0]), .branch_cnt(bc_w[0]), .taken_cnt(tc_w[0]));

  branch_resolve_unit #(.DELAY_SLOT(0)) u1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .id_valid(id_valid),
    .id_b_instr(id_b_instr), .id_jump(id_jump), .id_jr(id_jr),
    .id_opcode(id_opcode), .id_rt(id_rt), .id_ta(id_ta), .id_rs_val(id_rs_val),
    .ex_z(ex_z), .ex_n(ex_n), .npc_in(npc_in), .next_pc(npc_w[1]),
    .redirect(red_w[1]), .flush_if(fif_w[1]), .flush_id(fid_w[1]),
    .busy(busy_w[1]), .branch_cnt(bc_w[1]), .taken_cnt(tc_w[1]));

  branch_resolve_unit #(.CNT_W(2)) u2 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .id_valid(id_valid),
    .id_b_instr(id_b_instr), .id_jump(id_jump), .id_jr(id_jr),
    .id_opcode(id_opcode), .id_rt(id_rt), .id_ta(id_ta), .id_rs_val(id_rs_val),
    .ex_z(ex_z), .ex_n(ex_n), .npc_in(npc_in), .next_pc(npc_w[2]),
    .redirect(red_w[2]), .flush_if(fif_w[2]), .flush_id(fid_w[2]),
    .busy(busy_w[2]), .branch_cnt(sat_bc), .taken_cnt(sat_tc));

  // ---------------- reference model ----------------
  int          ds   [3] = '{1, 0, 1};
  int          cmax [3] = '{65535, 65535, 3};
  bit          m_pend [3];
  logic [5:0]  m_op [3];
  logic [4:0]  m_rt [3];
  logic [31:0] m_ta [3];
  int          m_bc [3], m_tc [3];

  function automatic bit br_taken(logic [5:0] op, logic [4:0] rt, logic z, logic n);
    case (op)
      6'd4: return z;                 // BEQ
      6'd5: return !z;                // BNE
      6'd6: return z || n;            // BLEZ
      6'd7: return !z && !n;          // BGTZ
      6'd1: begin
        if (rt == 5'd0 || rt == 5'd16) return n;   // BLTZ(AL)
        if (rt == 5'd1 || rt == 5'd17) return !n;  // BGEZ(AL)
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken(int k);
    return m_pend[k] && br_taken(m_op[k], m_rt[k], ex_z, ex_n) && !stall;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 1'b0; m_op[k] = '0; m_rt[k] = '0; m_ta[k] = '0;
      m_bc[k] = 0; m_tc[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit t;
      t = m_taken(k);
      if (!stall) begin
        if (m_pend[k]) begin
          if (m_bc[k] < cmax[k]) m_bc[k]++;
          if (t && m_tc[k] < cmax[k]) m_tc[k]++;
        end
        m_pend[k] = id_valid && id_b_instr && !t;
        if (m_pend[k]) begin
          m_op[k] = id_opcode; m_rt[k] = id_rt; m_ta[k] = id_ta;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      bit t, j;
      logic [31:0] pc;
      t  = m_taken(k);
      j  = !stall && id_valid && (id_jump || id_jr) && !t;
      pc = t ? m_ta[k] : (j ? (id_jr ? id_rs_val : id_ta) : npc_in);
      chk($sformatf("u%0d next_pc", k), npc_w[k], pc);
      chk($sformatf("u%0d redirect", k), red_w[k], t || j);
      chk($sformatf("u%0d flush_if", k), fif_w[k], t || (j && ds[k] == 0));
      chk($sformatf("u%0d flush_id", k), fid_w[k], t && ds[k] == 0);
      chk($sformatf("u%0d busy", k), busy_w[k], m_pend[k]);
      chk($sformatf("u%0d branch_cnt", k), bc_w[k], m_bc[k]);
      chk($sformatf("u%0d taken_cnt", k), tc_w[k], m_tc[k]);
    end
  endtask

  task automatic drive(input logic st, input logic v, input logic b, input logic j,
                       input logic jr, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] ta, input logic [31:0] rs, input logic z,
                       input logic n, input logic [31:0] npc);
    stall = st; id_valid = v; id_b_instr = b; id_jump = j; id_jr = jr;
    id_opcode = op; id_rt = rt; id_ta = ta; id_rs_val = rs;
    ex_z = z; ex_n = n; npc_in = npc;
  endtask

  // One model-checked cycle with the given inputs.
  task automatic cycle(input logic st, input logic v, input logic b, input logic j,
                       input logic jr, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] ta, input logic [31:0] rs, input logic z,
                       input logic n, input logic [31:0] npc);
    @(negedge clk);
    drive(st, v, b, j, jr, op, rt, ta, rs, z, n, npc);
    #1;
    check_model();
    @(posedge clk);
    model_step();
  endtask

  // ---------------- directed table (u0, one delay slot) ----------------
  typedef struct {
    logic st, v, b, j, jr;
    logic [5:0] op; logic [4:0] rt;
    logic [31:0] ta, rs;
    logic z, n;
    logic [31:0] npc;
    logic [31:0] e_pc;
    logic e_red, e_fif, e_fid, e_busy;
    logic [15:0] e_bc, e_tc;
  } vec_t;

  vec_t tbl [13];

  logic [5:0] ops [8] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
  logic [4:0] rts [5] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2};

  initial begin
    tbl[0]  = '{0,1,1,0,0,6'd4,5'd0,32'h40,32'h0,0,0,32'h104, 32'h104,0,0,0,0,16'd0,16'd0};
    tbl[1]  = '{0,0,0,0,0,6'd0,5'd0,32'h0,32'h0,1,0,32'h108, 32'h40,1,1,0,1,16'd0,16'd0};
    tbl[2]  = '{0,0,0,0,0,6'd0,5'd0,32'h0,32'h0,0,0,32'h10c, 32'h10c,0,0,0,0,16'd1,16'd1};
    tbl[3]  = '{0,1,1,0,0,6'd1,5'd1,32'h80,32'h0,0,0,32'h110, 32'h110,0,0,0,0,16'd1,16'd1};
    tbl[4]  = '{0,1,1,0,0,6'd5,5'd0,32'h200,32'h0,0,1,32'h114, 32'h114,0,0,0,1,16'd1,16'd1};
    tbl[5]  = '{0,0,0,0,0,6'd0,5'd0,32'h0,32'h0,0,0,32'h118, 32'h200,1,1,0,1,16'd2,16'd1};
    tbl[6]  = '{0,1,0,0,1,6'd0,5'd0,32'h0,32'h1234,0,0,32'h11c, 32'h1234,1,0,0,0,16'd3,16'd2};
    tbl[7]  = '{0,1,1,0,0,6'd7,5'd0,32'h300,32'h0,0,0,32'h120, 32'h120,0,0,0,0,16'd3,16'd2};
    tbl[8]  = '{1,1,0,0,1,6'd0,5'd0,32'h0,32'h1234,0,0,32'h124, 32'h124,0,0,0,1,16'd3,16'd2};
    tbl[9]  = '{1,1,0,0,1,6'd0,5'd0,32'h0,32'h1234,0,0,32'h128, 32'h128,0,0,0,1,16'd3,16'd2};
    tbl[10] = '{1,1,0,0,1,6'd0,5'd0,32'h0,32'h1234,0,0,32'h12c, 32'h12c,0,0,0,1,16'd3,16'd2};
    tbl[11] = '{0,1,0,1,0,6'd0,5'd0,32'h500,32'h0,0,0,32'h130, 32'h300,1,1,0,1,16'd3,16'd2};
    tbl[12] = '{0,0,0,0,0,6'd0,5'd0,32'h0,32'h0,0,0,32'h134, 32'h134,0,0,0,0,16'd4,16'd3};

    // clock/reset
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h100);
    model_reset();
    #2;
    chk("reset redirect", red_w[0], 1'b0);
    chk("reset busy", busy_w[0], 1'b0);
    chk("reset next_pc", npc_w[0], 32'h100);
    chk("reset branch_cnt", bc_w[0], 16'd0);
    chk("reset taken_cnt", tc_w[0], 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].st, tbl[i].v, tbl[i].b, tbl[i].j, tbl[i].jr, tbl[i].op, tbl[i].rt,
            tbl[i].ta, tbl[i].rs, tbl[i].z, tbl[i].n, tbl[i].npc);
      #1;
      chk($sformatf("tbl%0d next_pc", i), npc_w[0], tbl[i].e_pc);
      chk($sformatf("tbl%0d redirect", i), red_w[0], tbl[i].e_red);
      chk($sformatf("tbl%0d flush_if", i), fif_w[0], tbl[i].e_fif);
      chk($sformatf("tbl%0d flush_id", i), fid_w[0], tbl[i].e_fid);
      chk($sformatf("tbl%0d busy", i), busy_w[0], tbl[i].e_busy);
      chk($sformatf("tbl%0d branch_cnt", i), bc_w[0], tbl[i].e_bc);
      chk($sformatf("tbl%0d taken_cnt", i), tc_w[0], tbl[i].e_tc);
      check_model();
      @(posedge clk);
      model_step();
    end

    // Reset while a BEQ sits in EX with its condition true.
    cycle(0, 1, 1, 0, 0, 6'd4, 5'd0, 32'h700, 32'h0, 0, 0, 32'h200);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 1, 0, 32'h204);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst redirect", red_w[0], 1'b0);
    chk("midrst busy", busy_w[0], 1'b0);
    chk("midrst next_pc", npc_w[0], 32'h204);
    chk("midrst branch_cnt", bc_w[0], 16'd0);
    chk("midrst taken_cnt", tc_w[0], 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("postrst redirect", red_w[0], 1'b0);
    chk("postrst busy", busy_w[0], 1'b0);
    check_model();
    @(posedge clk);
    model_step();

    // Five taken BEQs: the 2-bit counters must stop at 3.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1, 0, 0, 6'd4, 5'd0, 32'h800 + 32'(i), 32'h0, 0, 0, 32'h300);
      cycle(0, 0, 0, 0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 1, 0, 32'h304);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h308);
    #1;
    chk("sat branch_cnt", sat_bc, 2'd3);
    chk("sat taken_cnt", sat_tc, 2'd3);
    chk("wide branch_cnt", bc_w[0], 16'd5);
    chk("wide taken_cnt", tc_w[0], 16'd5);
    @(posedge clk);
    model_step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ops[$urandom_range(0, 7)], rts[$urandom_range(0, 4)],
            $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
